axon_input_load_ctrl: RTL

AXON_INPUT_LOAD_CTRL -- requirements
Module: axon_input_load_ctrl

---
 rtl/axon_pkg.sv | 15 +
 rtl/axon_input_load_ctrl_if.sv | 11 +
 rtl/axon_load_addr_gen.sv | 46 ++++
 rtl/axon_input_load_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/axon_pkg.sv
// Shared types and default sizing for the axon input load controller.
package axon_pkg;

    localparam int DEF_ADDRESS_LENGTH = 13;
    localparam int DEF_MAX_COUNT      = 512;
    localparam int DEF_ROW_LEN        = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_ROW_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/axon_input_load_ctrl_if.sv
// Valid/ready input stream feeding the load controller.
interface axon_input_load_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/axon_load_addr_gen.sv
// Word index counter k with row-end and terminal-word detection.
module axon_load_addr_gen
    import axon_pkg::*;
#(
    parameter int ADDRESS_LENGTH = DEF_ADDRESS_LENGTH,
    parameter int MAX_COUNT      = DEF_MAX_COUNT,
    parameter int ROW_LEN        = DEF_ROW_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [ADDRESS_LENGTH-1:0] addr,
    output logic                      row_end,
    output logic                      last
);

    localparam logic [ADDRESS_LENGTH-1:0] LAST_IDX = ADDRESS_LENGTH'(MAX_COUNT - 1);
    localparam logic [ADDRESS_LENGTH-1:0] ROW_MASK = ADDRESS_LENGTH'(ROW_LEN - 1);

    logic [ADDRESS_LENGTH-1:0] k_q;
    logic [ADDRESS_LENGTH-1:0] k_d;

    // Saturates at the terminal index; the FSM leaves LOAD on that word anyway.
    always_comb begin
        k_d = k_q;
        if (clr) begin
            k_d = '0;
        end else if (inc && (k_q != LAST_IDX)) begin
            k_d = k_q + ADDRESS_LENGTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign addr    = k_q;
    assign row_end = ((k_q & ROW_MASK) == ROW_MASK);
    assign last    = (k_q == LAST_IDX);

endmodule

// File: rtl/axon_input_load_ctrl.sv
// Loads MAX_COUNT stream words into a buffer, one registered write per handshake.
// Optional per-row flow control (ROW_WAIT held until row_ack) under macro AXON_ROW_STALL_EN.
module axon_input_load_ctrl
    import axon_pkg::*;
#(
    parameter int ADDRESS_LENGTH = DEF_ADDRESS_LENGTH,
    parameter int MAX_COUNT      = DEF_MAX_COUNT,
    parameter int DATA_WIDTH     = 16,
    parameter int ROW_LEN        = DEF_ROW_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    axon_input_load_ctrl_if.slave     s,
    input  logic                      row_ack,
    output logic                      mem_we,
    output logic [ADDRESS_LENGTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      row_done,
    output logic                      busy,
    output logic                      done
);

`ifdef AXON_ROW_STALL_EN
    localparam bit ROW_STALL = 1'b1;
`else
    localparam bit ROW_STALL = 1'b0;
`endif

    state_t                    state_q,     state_d;
    logic                      mem_we_q,    mem_we_d;
    logic [ADDRESS_LENGTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic                      row_done_q,  row_done_d;
    logic                      busy_q,      busy_d;
    logic                      done_q,      done_d;

    logic                      k_clr;
    logic                      k_inc;
    logic [ADDRESS_LENGTH-1:0] k;
    logic                      k_row_end;
    logic                      k_last;
    logic                      hs;
    logic                      row_ack_en;

    axon_load_addr_gen #(
        .ADDRESS_LENGTH (ADDRESS_LENGTH),
        .MAX_COUNT      (MAX_COUNT),
        .ROW_LEN        (ROW_LEN)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (k_clr),
        .inc     (k_inc),
        .addr    (k),
        .row_end (k_row_end),
        .last    (k_last)
    );

    assign s.s_ready  = (state_q == ST_LOAD);
    assign hs         = s.s_valid && (state_q == ST_LOAD);
    assign row_ack_en = ROW_STALL && row_ack;

    // done/busy settle one cycle after entering DONE, so the final write is seen while still busy.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        row_done_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        k_clr       = 1'b0;
        k_inc       = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            k_clr   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_d = 1'b0;
                    if (start) begin
                        state_d = ST_LOAD;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        k_clr   = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        k_inc       = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = k;
                        mem_wdata_d = s.s_data;
                        row_done_d  = k_row_end;
                        if (k_last) begin
                            state_d = ST_DONE;
                        end else if (ROW_STALL && k_row_end) begin
                            state_d = ST_ROW_WAIT;
                        end
                    end
                end
                ST_ROW_WAIT: begin
                    if (row_ack_en) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    if (start) begin
                        state_d = ST_LOAD;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        k_clr   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            row_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            row_done_q  <= row_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign row_done  = row_done_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
